draw_port_arbiter: RTL and testbench
====================================

Name: draw_port_arbiter

Overview:
- Parametrised successor to the fixed two-client screen draw mux: N drawing clients (board fill, square mapper, text and cursor painters) share one VGA adapter pixel port.
- After reset, channel 0 (the full-screen fill) runs exclusively. After that, the remaining requests are served round-robin with a start/done handshake.
- Adds a per-grant watchdog and a re-arm rule (req must drop before the next grant). Sits between the clients and the vga_adapter pixel inputs.

Parameters:
- N_CH, 4, number of client channels (2..8); channel 0 is the boot-fill channel
- XW, 9, pixel x width (320 columns)
- YW, 8, pixel y width (240 rows)
- CW, 3, colour width
- TIMEOUT_CYCLES, 131072, maximum cycles a grant may be held without done; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_CH  per-channel draw request, level, held until done
- cl_x  in  N_CH*XW  packed client x; channel i at [i*XW +: XW]
- cl_y  in  N_CH*YW  packed client y
- cl_colour  in  N_CH*CW  packed client colour
- cl_plot  in  N_CH  client plot strobe
- cl_done  in  N_CH  client done, level or pulse
- start  out  N_CH  one-hot grant; drives the client's start input
- vga_x  out  XW  to adapter x
- vga_y  out  YW  to adapter y
- vga_colour  out  CW  to adapter colour
- vga_plot  out  1  to adapter plot
- busy  out  1  a grant is active
- boot_done  out  1  sticky; channel 0 boot fill has completed
- active_ch  out  $clog2(N_CH)  index of the granted channel; 0 when idle
- timeout_err  out  N_CH  sticky per-channel watchdog flags

Behaviour:
- Reset values (asynchronous, active-high): state=BOOT; start=0, except start[0]=1 from the first clock after reset release; vga_*=0; busy=0; boot_done=0; active_ch=0; timeout_err=0; rr_ptr=1; armed=all 1; watchdog counter=0.
- Reset asserted mid-draw aborts immediately: all starts drop and the next phase is BOOT again.
- State BOOT:
  - start[0]=1 and busy=1; req[0] is ignored.
  - On cl_done[0]: boot_done<=1, start[0]<=0, next state RELEASE.
- State IDLE:
  - A channel is eligible when req[i]&armed[i].
  - Round-robin search begins at rr_ptr and wraps modulo N_CH. Channel 0 participates after boot, e.g. for a redraw.
  - On a winner w: start[w]<=1 on the next edge, active_ch<=w, counter<=0, next state GRANT. No eligible channel: stay in IDLE.
- State GRANT:
  - Counter increments each cycle.
  - On cl_done[w]: start[w]<=0, armed[w]<=0, rr_ptr<=(w+1) mod N_CH, next state RELEASE.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no done: take the same release actions and set timeout_err[w]<=1.
  - If done and timeout coincide, done wins and no error flag is set.
- State RELEASE: exactly one cycle with busy=0 and start=0, then IDLE. This guarantees at least one dead cycle between grants.
- Re-arm: armed[i]<=1 in any cycle where req[i]==0.
  - Consequence: a client holding req after done is not re-granted until it drops req for at least one cycle.
  - Simultaneous req low and done: done clears armed, then the low req re-arms it next cycle.
- Pixel path: registered, 1-cycle latency.
  - vga_x/y/colour <= the granted channel's slice.
  - vga_plot <= cl_plot[w] & start[w].
  - Outside BOOT/GRANT: vga_plot<=0 and x/y/colour hold their last values.
- Plots from non-granted channels are dropped and never forwarded.
- start[w] is held continuously for the whole grant; clients see a level start, not a pulse.
- busy = (state==BOOT)|(state==GRANT).
- Request arriving in the same cycle as another channel's done: arbitration uses the post-RELEASE cycle, so it is served if eligible.
- All-ones req: order is 1,2,3,0,1,… with one grant plus one RELEASE cycle per turn.

Decomposition:
- Package draw_pkg: state enum (BOOT, IDLE, GRANT, RELEASE) and default XW/YW/CW constants shared with blankboard and squaremapper.
- One sub-module, rr_pick: combinational round-robin picker with inputs eligible[N_CH] and rr_ptr, outputs valid and winner index.

Test Plan:
- Reset release with all req=0: start=0001 from cycle 1. cl_done[0] at cycle 100 → start=0000 at 101, boot_done=1, busy=0 for one cycle, then IDLE.
- After boot, req=0110 held:
  - channel 1 granted first; the plot at (x=17,y=42,colour=5) appears on vga_* one cycle later;
  - after done, channel 2 granted following one RELEASE cycle;
  - channel 1 is not re-granted until its req drops.
- Channel 3 plots while channel 1 is granted → vga_plot stays 0 for channel 3's strobes.
- TIMEOUT_CYCLES=16, channel 2 granted and never signals done → start[2] drops after 16 cycles, timeout_err=0100 sticky, next eligible channel granted.
- rst pulsed while channel 1 is granted → start=0 asynchronously, timeout_err cleared, start[0]=1 re-asserted after rst falls.
- req=1111 held, done pulses returned after 3 cycles each, re-arming between turns → grant order 1,2,3,0,1 verified over 5 grants.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and default pixel geometry for the screen-drawing blocks
// (draw_port_arbiter, blankboard, squaremapper).
package draw_pkg;

  localparam int DRAW_XW = 9;  // 320 columns
  localparam int DRAW_YW = 8;  // 240 rows
  localparam int DRAW_CW = 3;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } draw_state_t;

endpackage

// File: rtl/draw_port_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible channel at or after
// rr_ptr, wrapping modulo N_CH.
module rr_pick #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         eligible,
  input  logic [$clog2(N_CH)-1:0] rr_ptr,
  output logic                    valid,
  output logic [$clog2(N_CH)-1:0] winner
);

  localparam int IW = $clog2(N_CH);

  // Scanning from the farthest offset down lets the nearest eligible channel
  // overwrite earlier hits, so no loop break is needed.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    valid  = 1'b0;
    winner = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (eligible[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/draw_port_arbiter.sv
// Shares the VGA adapter pixel port among N_CH drawing clients: channel 0
// boot fill first, then round-robin grants with watchdog and re-arm.
module draw_port_arbiter
  import draw_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int XW             = DRAW_XW,
  parameter int YW             = DRAW_YW,
  parameter int CW             = DRAW_CW,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*XW-1:0]      cl_x,
  input  logic [N_CH*YW-1:0]      cl_y,
  input  logic [N_CH*CW-1:0]      cl_colour,
  input  logic [N_CH-1:0]         cl_plot,
  input  logic [N_CH-1:0]         cl_done,
  output logic [N_CH-1:0]         start,
  output logic [XW-1:0]           vga_x,
  output logic [YW-1:0]           vga_y,
  output logic [CW-1:0]           vga_colour,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    boot_done,
  output logic [$clog2(N_CH)-1:0] active_ch,
  output logic [N_CH-1:0]         timeout_err
);

  localparam int IW   = $clog2(N_CH);
  localparam int CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  draw_state_t     state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic [N_CH-1:0] armed_q, armed_d;
  logic [IW-1:0]   rr_ptr_q;
  logic [N_CH-1:0] start_d;
  logic [IW-1:0]   grant_ch_d, src_ch;
  logic            pick_valid, done_w, timeout_hit, release_grant, pix_en;
  logic [IW-1:0]   pick_w;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .eligible (req & armed_q),
    .rr_ptr   (rr_ptr_q),
    .valid    (pick_valid),
    .winner   (pick_w)
  );

  assign done_w        = cl_done[active_ch];
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));
  assign release_grant = (state_q == ST_GRANT) && (done_w || timeout_hit);
  // start is registered and one-hot, so this is glitch-free and low in reset.
  assign busy          = |start;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:    if (cl_done[0]) state_d = ST_RELEASE;
      ST_IDLE:    if (pick_valid) state_d = ST_GRANT;
      ST_GRANT:   if (done_w || timeout_hit) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    grant_ch_d = (state_q == ST_IDLE) ? pick_w : active_ch;
    start_d    = '0;
    if (state_d == ST_BOOT)       start_d[0]          = 1'b1;
    else if (state_d == ST_GRANT) start_d[grant_ch_d] = 1'b1;
    src_ch  = (state_q == ST_GRANT) ? active_ch : '0;
    pix_en  = (state_q == ST_BOOT) || (state_q == ST_GRANT);
    // Done beats the re-arm: a client dropping req with done re-arms a cycle later.
    armed_d = armed_q | ~req;
    if (release_grant) armed_d[active_ch] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start       <= '0;
      active_ch   <= '0;
      cnt_q       <= '0;
      armed_q     <= '1;
      rr_ptr_q    <= IW'(1);
      boot_done   <= 1'b0;
      timeout_err <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
    end else begin
      start   <= start_d;
      armed_q <= armed_d;
      if (state_q == ST_BOOT && cl_done[0]) boot_done <= 1'b1;
      if (state_q == ST_IDLE && pick_valid) begin
        active_ch <= pick_w;
        cnt_q     <= '0;
      end else if (state_q == ST_GRANT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (release_grant) begin
        rr_ptr_q  <= (active_ch == IW'(N_CH - 1)) ? '0 : active_ch + 1'b1;
        active_ch <= '0;
        if (!done_w) timeout_err[active_ch] <= 1'b1;
      end
      if (pix_en) begin
        vga_x      <= cl_x[int'(src_ch)*XW +: XW];
        vga_y      <= cl_y[int'(src_ch)*YW +: YW];
        vga_colour <= cl_colour[int'(src_ch)*CW +: CW];
        vga_plot   <= cl_plot[src_ch] & start[src_ch];
      end else begin
        vga_plot   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Directed bench for draw_port_arbiter: boot fill, round-robin, plot gating,
// watchdog, re-arm and mid-grant reset.
module tb_draw_port_arbiter;

  localparam int N_CH = 4;
  localparam int XW = 9, YW = 8, CW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   req, cl_plot, cl_done;
  logic [N_CH*XW-1:0] cl_x;
  logic [N_CH*YW-1:0] cl_y;
  logic [N_CH*CW-1:0] cl_colour;
  logic [N_CH-1:0]   start, timeout_err;
  logic [XW-1:0]     vga_x;
  logic [YW-1:0]     vga_y;
  logic [CW-1:0]     vga_colour;
  logic              vga_plot, busy, boot_done;
  logic [1:0]        active_ch;

  int total = 0;
  int bad   = 0;

  draw_port_arbiter #(
    .N_CH(N_CH), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .cl_x(cl_x), .cl_y(cl_y),
    .cl_colour(cl_colour), .cl_plot(cl_plot), .cl_done(cl_done),
    .start(start), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .boot_done(boot_done),
    .active_ch(active_ch), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N_CH-1:0] v);
    int r = -1;
    for (int i = 0; i < N_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int exp_order [5] = '{1, 2, 3, 0, 1};
    int w;

    rst = 1'b1; req = '0; cl_plot = '0; cl_done = '0;
    cl_x = '0; cl_y = '0; cl_colour = '0;
    tick(); tick();
    check("rst_start", start, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_boot_done", boot_done, 0);
    check("rst_active_ch", active_ch, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_vga_plot", vga_plot, 0);

    // Boot fill: start[0] from cycle 1, done in cycle 100.
    rst = 1'b0;
    tick();
    check("boot_start", start, 4'b0001);
    check("boot_busy", busy, 1);
    repeat (98) tick();
    check("boot_held", start, 4'b0001);
    cl_done[0] = 1'b1;
    tick();
    cl_done[0] = 1'b0;
    check("boot_release_start", start, 4'b0000);
    check("boot_done_set", boot_done, 1);
    check("boot_release_busy", busy, 0);
    tick();
    check("idle_start", start, 4'b0000);
    check("idle_busy", busy, 0);

    // Channel 1 first; its plot is forwarded, channel 3's strobes are not.
    req = 4'b0110;
    tick();
    check("grant1_start", start, 4'b0010);
    check("grant1_active", active_ch, 1);
    cl_x[1*XW +: XW] = 9'd17;
    cl_y[1*YW +: YW] = 8'd42;
    cl_colour[1*CW +: CW] = 3'd5;
    cl_x[3*XW +: XW] = 9'd200;
    cl_plot = 4'b1010;
    tick();
    check("pix_x", vga_x, 17);
    check("pix_y", vga_y, 42);
    check("pix_colour", vga_colour, 5);
    check("pix_plot", vga_plot, 1);
    cl_plot = 4'b1000;
    tick();
    check("ch3_plot_dropped", vga_plot, 0);
    check("ch3_x_not_forwarded", vga_x, 17);

    // Done on channel 1 -> RELEASE, IDLE, then channel 2.
    cl_done[1] = 1'b1;
    tick();
    cl_done[1] = 1'b0;
    cl_plot = '0;
    check("rel1_start", start, 4'b0000);
    check("rel1_busy", busy, 0);
    tick();
    check("idle2_start", start, 4'b0000);
    tick();
    check("grant2_start", start, 4'b0100);
    check("grant2_active", active_ch, 2);

    // Watchdog: channel 2 never finishes; start held for 16 cycles.
    repeat (15) tick();
    check("wd_still_held", start, 4'b0100);
    check("wd_no_err_yet", timeout_err, 0);
    req = 4'b1110;
    tick();
    check("wd_release", start, 4'b0000);
    check("wd_err", timeout_err, 4'b0100);
    tick(); tick();
    check("after_wd_grant3", start, 4'b1000);
    check("wd_err_sticky", timeout_err, 4'b0100);
    cl_done[3] = 1'b1;
    req[3] = 1'b0;
    tick();
    cl_done[3] = 1'b0;
    check("rel3_start", start, 4'b0000);

    // Channels 1 and 2 hold req after done and must stay unarmed.
    repeat (3) tick();
    check("no_regrant_held_req", start, 4'b0000);
    check("no_regrant_busy", busy, 0);
    req = 4'b0100;
    tick();
    check("rearm_cycle_start", start, 4'b0000);
    req = 4'b0110;
    tick();
    check("regrant1_start", start, 4'b0010);

    // Asynchronous reset mid-grant.
    rst = 1'b1;
    #1;
    check("midrst_start", start, 4'b0000);
    check("midrst_timeout_err", timeout_err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_boot_done", boot_done, 0);
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    check("reboot_start", start, 4'b0001);
    cl_done[0] = 1'b1;
    tick();
    cl_done[0] = 1'b0;
    check("reboot_release", start, 4'b0000);

    // All-ones req, 3-cycle grants, req dropped for one cycle after done.
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int t = 0; t < 20 && start == '0; t++) tick();
      check("rr_granted", {31'd0, |start}, 1);
      w = onehot_idx(start);
      check("rr_order", w, exp_order[g]);
      check("rr_active", active_ch, exp_order[g]);
      tick(); tick();
      if (w >= 0) cl_done[w] = 1'b1;
      tick();
      cl_done = '0;
      if (w >= 0) req[w] = 1'b0;
      tick();
      req = 4'b1111;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
